// File: rtl/oled_pkg.sv
// State encoding and frame constants shared by the SSD1306 SPI transmitter.
package oled_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD,
        ST_GAP
    } state_t;

    // SETUP + 8 HIGH + 7 LOW + HOLD + GAP
    localparam int FRAME_PHASES = 18;

endpackage

// File: rtl/oled_phase_timer.sv
// Counts HALF_DIV clock cycles per SCK half-period; tc_o flags the last cycle of a phase.
// Zero latency on tc_o; clr_i forces the count back to 0 on the next edge.
module oled_phase_timer #(
    parameter int HALF_DIV = 250
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam int             CW   = $clog2(HALF_DIV + 1);
    localparam logic [CW-1:0]  LAST = CW'(HALF_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/oled_spi_tx.sv
// Mode-0, MSB-first SPI byte transmitter for the SSD1306; one byte plus D/C per handshake.
// CS drops the cycle after accept, busy lasts 18*HALF_DIV cycles; requests while busy are dropped.
module oled_spi_tx
    import oled_pkg::*;
#(
    parameter int HALF_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_en,
    input  logic       send_dc,
    input  logic [7:0] send_data,
    output logic       send_busy,
    output logic       oled_cs,
    output logic       oled_sck,
    output logic       oled_dc,
    output logic       oled_mosi
);

    state_t     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic       dc_q, dc_d;
    logic       busy_q, busy_d;
    logic       cs_q, cs_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;
    logic       phase_tc;
    logic       phase_clr;

    // Held at zero while idle so every phase starts from a clean count.
    assign phase_clr = (state_q == ST_IDLE) || (state_d != state_q);

    oled_phase_timer #(
        .HALF_DIV (HALF_DIV)
    ) u_phase_timer (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (phase_clr),
        .tc_o  (phase_tc)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        dc_d     = dc_q;

        case (state_q)
            ST_IDLE: begin
                if (send_en) begin
                    state_d  = ST_SETUP;
                    shreg_d  = send_data;
                    dc_d     = send_dc;
                    bitcnt_d = 3'd0;
                end
            end
            ST_SETUP: begin
                if (phase_tc) state_d = ST_HIGH;
            end
            ST_HIGH: begin
                if (phase_tc) begin
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_LOW;
                        shreg_d = {shreg_q[6:0], 1'b0};
                    end
                end
            end
            ST_LOW: begin
                if (phase_tc) state_d = ST_HIGH;
            end
            ST_HOLD: begin
                if (phase_tc) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (phase_tc) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        busy_d = (state_d != ST_IDLE);
        cs_d   = (state_d == ST_IDLE) || (state_d == ST_GAP);
        sck_d  = (state_d == ST_HIGH);
        mosi_d = ((state_d == ST_SETUP) || (state_d == ST_HIGH) || (state_d == ST_LOW))
                 ? shreg_d[7] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            dc_q     <= 1'b0;
            busy_q   <= 1'b0;
            cs_q     <= 1'b1;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            dc_q     <= dc_d;
            busy_q   <= busy_d;
            cs_q     <= cs_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
        end
    end

    assign send_busy = busy_q;
    assign oled_cs   = cs_q;
    assign oled_sck  = sck_q;
    assign oled_dc   = dc_q;
    assign oled_mosi = mosi_q;

endmodule
